// File: rtl/zymason_pkg.sv
// Shared types and defaults for the zymason display frame loader.
package zymason_pkg;

  localparam int NUM_DIGITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    LO,
    HI,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/zymason_nib_mux.sv
// Selects the display data nibble and nibble-select line from the loader state.
module zymason_nib_mux
  import zymason_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] captured,
  input  logic [4:0] spd,
  output logic [3:0] pin_out,
  output logic       sel
);

  always_comb begin
    pin_out = 4'h0;
    sel     = 1'b0;
    case (state)
      IDLE, DONE: {pin_out, sel} = spd;
      // ADV rewrites the same low nibble while the display steps to the next position
      LO, ADV:    pin_out = captured[3:0];
      HI: begin
        pin_out = {1'b0, captured[6:4]};
        sel     = 1'b1;
      end
      default: begin
        pin_out = 4'h0;
        sel     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/zymason_loader.sv
// Loads NUM_DIGITS 7-bit segment patterns into a nibble-wide display core per frame.
module zymason_loader
  import zymason_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dig_valid,
  input  logic [6:0] dig_data,
  output logic       dig_ready,
  input  logic [4:0] spd,
  output logic       busy,
  output logic       done,
  output logic       disp_reset,
  output logic       rw,
  output logic       sel,
  output logic [3:0] pin_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [6:0]       captured_reg, captured_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      captured_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      captured_reg <= captured_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    captured_next = captured_reg;
    dig_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    disp_reset    = 1'b0;
    rw            = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CLR;
      end
      CLR: begin
        disp_reset = 1'b1;
        idx_next   = '0;
        state_next = FETCH;
      end
      FETCH: begin
        rw        = 1'b1;
        dig_ready = 1'b1;
        if (dig_valid) begin
          captured_next = dig_data;
          state_next    = LO;
        end
      end
      LO: begin
        rw         = 1'b1;
        state_next = HI;
      end
      HI: begin
        rw         = 1'b1;
        // the last digit never reaches ADV, so the index cannot wrap
        state_next = (idx_reg == LAST_IDX) ? DONE : ADV;
      end
      ADV: begin
        rw         = 1'b1;
        idx_next   = idx_reg + IDX_W'(1);
        state_next = FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  zymason_nib_mux u_nib_mux (
    .state    (state_reg),
    .captured (captured_reg),
    .spd      (spd),
    .pin_out  (pin_out),
    .sel      (sel)
  );

endmodule

// File: tb/tb_zymason_loader.sv
// Directed bench for zymason_loader with a behavioural model of the display core.
module tb_zymason_loader;

  logic       clock = 1'b0;
  logic       reset_n, start, dig_valid;
  logic [6:0] dig_data;
  logic       dig_ready;
  logic [4:0] spd;
  logic       busy, done, disp_reset, rw, sel;
  logic [3:0] pin_out;

  int errors = 0;
  int checks = 0;

  logic [6:0] data_q [8];
  logic [6:0] disp_mem [8];
  int disp_pos = 0;
  bit prev_sel = 1'b0;
  int writes = 0;
  int done_count = 0;

  int cyc, digit_idx, phase, stall_left, stall_digit;
  bit acc;

  always #5 clock = ~clock;

  zymason_loader #(.NUM_DIGITS(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dig_valid  (dig_valid),
    .dig_data   (dig_data),
    .dig_ready  (dig_ready),
    .spd        (spd),
    .busy       (busy),
    .done       (done),
    .disp_reset (disp_reset),
    .rw         (rw),
    .sel        (sel),
    .pin_out    (pin_out)
  );

  // Display core: sel=1 writes the high part, sel=0 the low nibble; a low write
  // straight after a high write finishes the digit and steps to the next position.
  always @(posedge clock) begin
    if (done) done_count++;
    if (disp_reset) begin
      for (int i = 0; i < 8; i++) disp_mem[i] = 7'h00;
      disp_pos = 0;
      prev_sel = 1'b0;
    end else if (rw) begin
      writes++;
      if (disp_pos < 8) begin
        if (sel) disp_mem[disp_pos][6:4] = pin_out[2:0];
        else     disp_mem[disp_pos][3:0] = pin_out;
      end
      if (!sel && prev_sel) disp_pos++;
      prev_sel = sel;
    end else begin
      prev_sel = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    acc = dig_ready && dig_valid;
    @(posedge clock);
    #1;
    cyc++;
    if (acc) begin
      digit_idx++;
      phase = 1;
    end else if (phase > 0 && phase < 4) begin
      phase++;
    end else begin
      phase = 0;
    end
    dig_data = (digit_idx < 8) ? data_q[digit_idx] : 7'h00;
    if (dig_ready && digit_idx == stall_digit && stall_left > 0) begin
      dig_valid = 1'b0;
      stall_left--;
    end else begin
      dig_valid = 1'b1;
    end
  endtask

  // Runs one frame; returns the cycle (start edge = 0) on which done was seen, or -1.
  task automatic run_frame(input int stall_d, input int stall_n, input int restart_cyc,
                           input bit abort, input bit check_7f, output int done_cycle);
    int wr0, dc0;
    cyc = 0; digit_idx = 0; phase = 0;
    stall_digit = stall_d; stall_left = stall_n;
    dig_data = data_q[0];
    dig_valid = 1'b1;
    done_cycle = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done_cycle < 0 && cyc < 100) begin
      tick();
      start = (cyc == restart_cyc);
      if (abort && digit_idx == 5 && rw && sel) begin
        reset_n = 1'b0;
        tick();
        wr0 = writes;
        dc0 = done_count;
        check("abort_busy", busy, 0);
        check("abort_ready", dig_ready, 0);
        check("abort_done", done, 0);
        check("abort_rw", rw, 0);
        check("abort_dreset", disp_reset, 0);
        reset_n = 1'b1;
        repeat (10) tick();
        check("abort_no_writes", writes, wr0);
        check("abort_no_done", done_count, dc0);
        check("abort_idle", busy, 0);
        return;
      end
      if (check_7f && phase == 1) check("lo_nib", {sel, pin_out}, 5'h0F);
      if (check_7f && phase == 2) check("hi_nib", {sel, pin_out}, 5'h17);
      if (check_7f && phase == 3 && digit_idx < 8) check("adv_nib", {sel, pin_out}, 5'h0F);
      if (done) done_cycle = cyc;
    end
  endtask

  initial begin
    int dcyc, dc0;
    start = 1'b0; dig_valid = 1'b0; dig_data = 7'h00;
    spd = 5'b10110;
    stall_digit = -1; stall_left = 0; cyc = 0; digit_idx = 0; phase = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rw", rw, 0);
    check("rst_pin", pin_out, 4'b1011);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", dig_ready, 0);
    check("rst_dreset", disp_reset, 0);
    reset_n = 1'b1;
    tick();

    // Plain frame, digits 1..8
    for (int i = 0; i < 8; i++) data_q[i] = 7'(i + 1);
    run_frame(-1, 0, -1, 1'b0, 1'b0, dcyc);
    check("frame_done_cycle", dcyc, 33);
    for (int i = 0; i < 8; i++) check($sformatf("disp%0d", i), disp_mem[i], 7'(i + 1));
    tick();
    check("after_busy", busy, 0);
    spd = 5'b01001;
    #1;
    check("idle_spd", {pin_out, sel}, 5'b01001);
    spd = 5'b10110;

    // Stall 5 cycles before digit 3
    data_q = '{7'h15, 7'h2A, 7'h3F, 7'h40, 7'h51, 7'h62, 7'h73, 7'h7E};
    run_frame(3, 5, -1, 1'b0, 1'b0, dcyc);
    check("stall_done_cycle", dcyc, 38);
    check("stall_d0", disp_mem[0], 7'h15);
    check("stall_d1", disp_mem[1], 7'h2A);
    check("stall_d2", disp_mem[2], 7'h3F);
    check("stall_d3", disp_mem[3], 7'h40);
    check("stall_d7", disp_mem[7], 7'h7E);
    tick();

    // Start pulsed again during the frame
    for (int i = 0; i < 8; i++) data_q[i] = 7'(i + 1);
    dc0 = done_count;
    run_frame(-1, 0, 10, 1'b0, 1'b0, dcyc);
    check("restart_done_cycle", dcyc, 33);
    repeat (40) tick();
    check("restart_done_once", done_count - dc0, 1);
    check("restart_idle", busy, 0);

    // Reset during HI of digit 4
    run_frame(-1, 0, -1, 1'b1, 1'b0, dcyc);
    check("abort_no_done_seen", dcyc, 32'hFFFF_FFFF);

    // All-ones pattern
    for (int i = 0; i < 8; i++) data_q[i] = 7'h7F;
    run_frame(-1, 0, -1, 1'b0, 1'b1, dcyc);
    check("ones_done_cycle", dcyc, 33);
    check("ones_d5", disp_mem[5], 7'h7F);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zymason_loader.md
ZYMASON_LOADER -- requirements
Module: zymason_loader

Interface
REQ-001 The module SHALL take parameter NUM_DIGITS, default 8, as the number of display digits loaded per frame.
REQ-002 The module SHALL have port clock, input, 1 bit, the single clock for all state.
REQ-003 The module SHALL have port reset_n, input, 1 bit, which is a synchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit, a one-cycle request to begin a frame load.
REQ-005 The module SHALL have port dig_valid, input, 1 bit, meaning dig_data holds the next digit.
REQ-006 The module SHALL have port dig_data, input, 7 bits, a segment pattern whose bits [3:0] are the low nibble and bits [6:4] the high part.
REQ-007 The module SHALL have port dig_ready, output, 1 bit, asserted when the module accepts dig_data this cycle.
REQ-008 The module SHALL have port spd, input, 5 bits, the display scan-speed code driven onto the bus while idle.
REQ-009 The module SHALL have port busy, output, 1 bit, high from the start acceptance until the frame completes.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle pulse when the last digit is written.
REQ-011 The module SHALL have port disp_reset, output, 1 bit, the active-high reset to the display core.
REQ-012 The module SHALL have port rw, output, 1 bit, the display write-mode line.
REQ-013 The module SHALL have port sel, output, 1 bit, the display nibble-select line.
REQ-014 The module SHALL have port pin_out, output, 4 bits, the display data nibble.

Function
REQ-015 The module SHALL implement a Moore FSM with states IDLE, CLR, FETCH, LO, HI, ADV and DONE, with all outputs decoded only from the state, the captured digit register and the index counter.
REQ-016 IDLE SHALL drive rw=0, {pin_out,sel}=spd, busy=0 and dig_ready=0, and SHALL move to CLR when start=1.
REQ-017 CLR SHALL last one cycle, drive disp_reset=1 and rw=0, clear the digit index to 0, and then move to FETCH.
REQ-018 FETCH SHALL drive rw=1, sel=0, pin_out=4'h0 and dig_ready=1; when dig_valid=1 it SHALL capture dig_data and move to LO, otherwise it SHALL stay in FETCH indefinitely.
REQ-019 LO SHALL drive rw=1, sel=0 and pin_out=captured[3:0], and SHALL move to HI.
REQ-020 HI SHALL drive rw=1, sel=1 and pin_out={1'b0,captured[6:4]}; it SHALL move to DONE if index==NUM_DIGITS-1, otherwise to ADV.
REQ-021 ADV SHALL drive rw=1, sel=0 and pin_out=captured[3:0], so the current digit's low nibble is rewritten unchanged while the display position advances; it SHALL increment the index and move to FETCH.
REQ-022 DONE SHALL last one cycle, drive rw=0, {pin_out,sel}=spd and done=1, and then move to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 A start asserted while busy=1 SHALL be ignored.
REQ-025 The index counter SHALL be $clog2(NUM_DIGITS) bits wide and SHALL never wrap within a frame.
REQ-026 The minimum frame length SHALL be 1+4*NUM_DIGITS cycles from CLR through DONE inclusive, which is 33 cycles for the default NUM_DIGITS of 8.
REQ-027 dig_ready SHALL be 1 only in FETCH, and at most one digit SHALL be accepted per FETCH visit.

Reset
REQ-028 While reset_n=0 at a clock edge, the module SHALL enter IDLE and clear the index and captured register to 0.
REQ-029 During reset the outputs SHALL be busy=0, done=0, dig_ready=0, disp_reset=0 and rw=0.
REQ-030 A reset that arrives mid-frame SHALL abandon the frame without any further display writes or a done pulse.

Structure
REQ-031 The state enum and the NUM_DIGITS default SHALL reside in the shared package zymason_pkg.
REQ-032 The block SHALL contain one sub-module, zymason_nib_mux, which combinationally selects pin_out and sel from the state, the captured digit and spd.

Verification
REQ-033 The bench SHALL cover: reset, then spd=5'b10110 -> rw=0, pin_out=4'b1011, sel=0, busy=0.
REQ-034 The bench SHALL cover: start with 8 digits always valid, data 7'h01..7'h08, connected to the display core -> after done the display holds digit i = i+1, and done is high on cycle 33 after start.
REQ-035 The bench SHALL cover: dig_valid held low for 5 cycles before digit 3 -> FETCH is held 5 extra cycles, digit 3 is still correct, and digits 0-2 are unchanged.
REQ-036 The bench SHALL cover: start pulsed again at cycle 10 of a frame -> no restart, and done occurs exactly once.
REQ-037 The bench SHALL cover: reset_n=0 during HI of digit 4 -> IDLE on the next cycle, with no done pulse and dig_ready=0.
REQ-038 The bench SHALL cover: dig_data=7'h7F for every digit -> pin_out sequence per digit is 0xF (LO), 0x7 with sel=1 (HI), 0xF (ADV).
